serial_slave_port_burst: RTL and testbench
==========================================

Name: serial_slave_port_burst

Overview:
Second-generation slave-side endpoint of the serial system bus. It deserialises a header (address plus burst length) and write data from the master over LANES bits per cycle, then drives the slave memory's wen/ren/addr/wdata strobes. On reads it serialises the returned data back to the master. It adds multi-lane transfer, bursts with incrementing addresses, a configurable memory read latency and an explicit ready indication, and sits between the bus interconnect and one slave memory.

Parameters:
ADDR_WIDTH, 12, slave memory address width; must be a multiple of LANES.
DATA_WIDTH, 8, memory word width; must be a multiple of LANES.
LANES, 1, serial bits transferred per valid cycle (1, 2, 4, ...).
BURST_WIDTH, 4, burst-length field width (value = words-1); must be a multiple of LANES.
RD_LATENCY, 1, cycles from the smemren cycle to smemrdata valid; must be >= 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
smemrdata  in  DATA_WIDTH  read data from slave memory
smemwen  out  1  memory write strobe, one-cycle pulse per word
smemren  out  1  memory read strobe, one-cycle pulse per word
smemaddr  out  ADDR_WIDTH  memory address
smemwdata  out  DATA_WIDTH  memory write data
swdata  in  LANES  header/write data from master, LSB-first
smode  in  1  0 = read, 1 = write; sampled on first header beat
mvalid  in  1  swdata beat valid
srdata  out  LANES  read data to master, LSB-first
svalid  out  1  srdata beat valid
sready  out  1  high when idle and able to accept a new header

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; counters, shift registers, word index and base address are cleared; all outputs 0 except sready=1. Mid-transaction reset aborts immediately. An uncompleted word is never written.
- Frame format: header of (ADDR_WIDTH+BURST_WIDTH)/LANES beats. Address is sent first, then burst length, LSB-first. Write frames follow with (len+1) words of DATA_WIDTH/LANES beats each.
- A beat is consumed only in a cycle with mvalid=1. mvalid=0 stalls the header or write phase with no state change. Gaps are unlimited.
- States:
  - IDLE: sready=1. If mvalid, capture beat 0 and smode, then go to HDR. If the header is one beat long, go directly to WDATA or RREQ.
  - HDR: shift beats in. After the last beat, go to WDATA if smode=1, else RREQ. sready=0 in all non-IDLE states.
  - WDATA: shift beats in. After the last beat of a word, go to WMEM.
  - WMEM (exactly 1 cycle): smemwen=1, smemaddr=(base+i) mod 2^ADDR_WIDTH, smemwdata=assembled word. Go to WDATA if words remain, else IDLE. mvalid in this cycle is ignored.
  - RREQ (exactly 1 cycle): smemren=1, smemaddr=(base+i) mod 2^ADDR_WIDTH. Go to RWAIT.
  - RWAIT (RD_LATENCY cycles): at the end of the last cycle, capture smemrdata into the output shift register and go to RDATA.
  - RDATA (DATA_WIDTH/LANES cycles, contiguous): svalid=1, srdata=next LANES bits LSB-first. After the last beat, go to RREQ if words remain, else IDLE.
- Read timing: smemren in cycle T; first svalid beat in cycle T+RD_LATENCY+1. Between words, svalid is low for RD_LATENCY+1 cycles.
- Master input during a read: mvalid and swdata are ignored from RREQ until the return to IDLE.
- Output defaults: smemwen, smemren, svalid and srdata are 0 outside their states. smemaddr and smemwdata hold their last driven values.
- Address arithmetic: the address wraps modulo 2^ADDR_WIDTH within a burst. The maximum burst is 2^BURST_WIDTH words.
- Back-to-back frames: the cycle after the final WMEM or RDATA beat is IDLE, and a header beat presented in that cycle is accepted.

Test Plan:
All scenarios use LANES=2, ADDR_WIDTH=12, DATA_WIDTH=8, BURST_WIDTH=4, RD_LATENCY=2.
1. Single write: addr 0x3A5, len 0, data 0xC3 (8 header + 4 data beats) -> exactly one smemwen pulse with smemaddr=0x3A5 and smemwdata=0xC3, the cycle after the 4th data beat; sready=1 the cycle after that.
2. Burst write: addr 0xFFE, len 3, data 0x11, 0x22, 0x33, 0x44 -> four smemwen pulses at 0xFFE, 0xFFF, 0x000, 0x001 with the matching data.
3. Single read: addr 0x010, memory returns 0x5A -> smemren in cycle T; svalid high in cycles T+3..T+6; srdata = 2'b10, 2'b10, 2'b01, 2'b01.
4. Header/write gaps: scenario 1 with mvalid low for 3 cycles after header beat 4 and after data beat 2 -> identical memory activity, delayed by 6 cycles.
5. Reset mid-burst: scenario 2 with rst pulsed during word 3's data beats -> exactly 2 smemwen pulses; all strobes 0 and sready=1 from the cycle after reset; a following single write completes normally.
6. Burst read: addr 0x7F0, len 1, memory returns 0xA5 then 0x3C -> two smemren pulses (0x7F0, 0x7F1); two 4-beat svalid groups separated by 3 low cycles; mvalid toggling during the read has no effect.

Source files
------------

// File: rtl/serial_slave_port_burst.sv
// Slave endpoint of the serial bus: deserialises a header and write data over LANES bits
// per beat, drives burst memory strobes, and serialises read data back to the master.
module serial_slave_port_burst #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 8,
   parameter int LANES       = 1,
   parameter int BURST_WIDTH = 4,
   parameter int RD_LATENCY  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] smemrdata,
   output logic                  smemwen,
   output logic                  smemren,
   output logic [ADDR_WIDTH-1:0] smemaddr,
   output logic [DATA_WIDTH-1:0] smemwdata,
   input  logic [LANES-1:0]      swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic [LANES-1:0]      srdata,
   output logic                  svalid,
   output logic                  sready
);

   localparam int HW   = ADDR_WIDTH + BURST_WIDTH;
   localparam int HB   = HW / LANES;
   localparam int DB   = DATA_WIDTH / LANES;
   localparam int MXHD = (HB > DB) ? HB : DB;
   localparam int MAXC = (MXHD > RD_LATENCY) ? MXHD : RD_LATENCY;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] HB_LAST = CW'(HB - 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);
   localparam logic [CW-1:0] RL_LAST = CW'(RD_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, HDR, WDATA, WMEM, RREQ, RWAIT, RDATA} state_t;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [HW-1:0]           hdr_q;
   logic [DATA_WIDTH-1:0]   wd_q;
   logic [DATA_WIDTH-1:0]   rd_q;
   logic [ADDR_WIDTH-1:0]   cur_addr_q;
   logic [BURST_WIDTH-1:0]  rem_q;
   logic                    mode_q;
   logic                    smemwen_q;
   logic                    smemren_q;
   logic [ADDR_WIDTH-1:0]   smemaddr_q;
   logic [DATA_WIDTH-1:0]   smemwdata_q;
   logic [LANES-1:0]        srdata_q;
   logic                    svalid_q;
   logic                    sready_q;

   // LSB-first shift: each new beat lands at the top and older beats move down.
   logic [HW+LANES-1:0]         hdr_cat;
   logic [DATA_WIDTH+LANES-1:0] wd_cat;
   logic [HW-1:0]               hdr_d;
   logic [DATA_WIDTH-1:0]       wd_d;
   logic [DATA_WIDTH-1:0]       rd_d;
   logic [ADDR_WIDTH-1:0]       hdr_addr;
   logic [BURST_WIDTH-1:0]      hdr_len;
   logic                        hdr_done;
   logic                        hdr_wr;

   assign hdr_cat  = {swdata, hdr_q};
   assign wd_cat   = {swdata, wd_q};
   assign hdr_d    = hdr_cat[HW+LANES-1:LANES];
   assign wd_d     = wd_cat[DATA_WIDTH+LANES-1:LANES];
   assign rd_d     = rd_q >> LANES;
   assign hdr_addr = hdr_d[ADDR_WIDTH-1:0];
   assign hdr_len  = hdr_d[HW-1:ADDR_WIDTH];
   assign hdr_wr   = (state_q == IDLE) ? smode : mode_q;
   assign hdr_done = mvalid && (((state_q == IDLE) && (HB == 1)) ||
                                ((state_q == HDR) && (cnt_q == HB_LAST)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hdr_q       <= '0;
         wd_q        <= '0;
         rd_q        <= '0;
         cur_addr_q  <= '0;
         rem_q       <= '0;
         mode_q      <= 1'b0;
         smemwen_q   <= 1'b0;
         smemren_q   <= 1'b0;
         smemaddr_q  <= '0;
         smemwdata_q <= '0;
         srdata_q    <= '0;
         svalid_q    <= 1'b0;
         sready_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: if (mvalid) begin
               hdr_q    <= hdr_d;
               mode_q   <= smode;
               cnt_q    <= CW'(1);
               sready_q <= 1'b0;
               state_q  <= HDR;
            end
            HDR: if (mvalid) begin
               hdr_q <= hdr_d;
               cnt_q <= cnt_q + CW'(1);
            end
            WDATA: if (mvalid) begin
               wd_q <= wd_d;
               if (cnt_q == DB_LAST) begin
                  cnt_q       <= '0;
                  smemwen_q   <= 1'b1;
                  smemaddr_q  <= cur_addr_q;
                  smemwdata_q <= wd_d;
                  state_q     <= WMEM;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            WMEM: begin
               smemwen_q <= 1'b0;
               if (rem_q == '0) begin
                  sready_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  rem_q      <= rem_q - BURST_WIDTH'(1);
                  cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
                  state_q    <= WDATA;
               end
            end
            RREQ: begin
               smemren_q <= 1'b0;
               cnt_q     <= '0;
               state_q   <= RWAIT;
            end
            RWAIT: if (cnt_q == RL_LAST) begin
               rd_q     <= smemrdata;
               srdata_q <= smemrdata[LANES-1:0];
               svalid_q <= 1'b1;
               cnt_q    <= '0;
               state_q  <= RDATA;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            RDATA: if (cnt_q == DB_LAST) begin
               svalid_q <= 1'b0;
               srdata_q <= '0;
               cnt_q    <= '0;
               if (rem_q == '0) begin
                  sready_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  rem_q      <= rem_q - BURST_WIDTH'(1);
                  cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
                  smemaddr_q <= cur_addr_q + ADDR_WIDTH'(1);
                  smemren_q  <= 1'b1;
                  state_q    <= RREQ;
               end
            end else begin
               rd_q     <= rd_d;
               srdata_q <= rd_d[LANES-1:0];
               cnt_q    <= cnt_q + CW'(1);
            end
            default: state_q <= IDLE;
         endcase
         // Final header beat overrides the shift-phase state update above.
         if (hdr_done) begin
            cnt_q      <= '0;
            cur_addr_q <= hdr_addr;
            rem_q      <= hdr_len;
            if (hdr_wr) begin
               state_q <= WDATA;
            end else begin
               smemren_q  <= 1'b1;
               smemaddr_q <= hdr_addr;
               state_q    <= RREQ;
            end
         end
      end
   end

   assign smemwen   = smemwen_q;
   assign smemren   = smemren_q;
   assign smemaddr  = smemaddr_q;
   assign smemwdata = smemwdata_q;
   assign srdata    = srdata_q;
   assign svalid    = svalid_q;
   assign sready    = sready_q;

endmodule

// File: tb/tb_serial_slave_port_burst.sv
// Directed bench for serial_slave_port_burst with LANES=2 and RD_LATENCY=2: single/burst
// writes and reads, input gaps, mid-burst reset, and ignored master input during reads.
module tb_serial_slave_port_burst;
   localparam int AW = 12, DW = 8, L = 2, BW = 4, RL = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] smemrdata;
   logic          smemwen, smemren, svalid, sready;
   logic [AW-1:0] smemaddr;
   logic [DW-1:0] smemwdata;
   logic [L-1:0]  swdata, srdata;
   logic          smode, mvalid;

   serial_slave_port_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(L),
                             .BURST_WIDTH(BW), .RD_LATENCY(RL)) dut (
      .clk(clk), .rst(rst), .smemrdata(smemrdata), .smemwen(smemwen), .smemren(smemren),
      .smemaddr(smemaddr), .smemwdata(smemwdata), .swdata(swdata), .smode(smode),
      .mvalid(mvalid), .srdata(srdata), .svalid(svalid), .sready(sready));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory with two-cycle read latency: data valid in cycle T+2 for smemren in cycle T.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] p1;
   always @(posedge clk) begin
      p1        <= smemren ? mem[smemaddr] : 8'hEE;
      smemrdata <= p1;
   end

   typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} ev_t;
   ev_t wq[$], rq[$], vq[$];

   always @(negedge clk) if (rst === 1'b0) begin
      if (smemwen) wq.push_back('{c: cyc, a: smemaddr, d: smemwdata});
      if (smemren) rq.push_back('{c: cyc, a: smemaddr, d: 8'h00});
      if (svalid)  vq.push_back('{c: cyc, a: 12'h000, d: {6'b0, srdata}});
   end

   int checks = 0, errors = 0;
   int last_c, start_c, s, c;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [1:0] d, input logic m);
      @(negedge clk);
      mvalid = 1'b1; swdata = d; smode = m;
      last_c = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mvalid = 1'b0; swdata = 2'b00;
      end
   endtask

   task automatic send_hdr(input logic [AW-1:0] a, input logic [BW-1:0] len, input logic m,
                           input int gap_at, input int gap_n);
      logic [AW+BW-1:0] h;
      h = {len, a};
      for (int k = 0; k < (AW+BW)/L; k++) begin
         beat(h[2*k +: 2], m);
         if (k == 0) start_c = last_c;
         if (k == gap_at) idle(gap_n);
      end
   endtask

   task automatic send_word(input logic [DW-1:0] w, input int gap_at, input int gap_n);
      for (int k = 0; k < DW/L; k++) begin
         beat(w[2*k +: 2], 1'b1);
         if (k == gap_at) idle(gap_n);
      end
   endtask

   function automatic ev_t nullev();
      return '{c: -1, a: 12'h000, d: 8'h00};
   endfunction

   logic [DW-1:0] words [4];
   logic [AW-1:0] baddr [4];

   initial begin
      words = '{8'h11, 8'h22, 8'h33, 8'h44};
      baddr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      rst = 1'b1; mvalid = 1'b0; swdata = 2'b00; smode = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_sready", sready, 1);
      chk("rst_wen", smemwen, 0);
      chk("rst_ren", smemren, 0);
      chk("rst_svalid", svalid, 0);
      chk("rst_srdata", srdata, 0);
      chk("rst_addr", smemaddr, 0);
      chk("rst_wdata", smemwdata, 0);
      rst = 1'b0;
      idle(2);

      // Single write
      wq.delete();
      send_hdr(12'h3A5, 4'd0, 1'b1, -1, 0);
      chk("s1_busy", sready, 0);
      s = start_c;
      send_word(8'hC3, -1, 0);
      c = last_c;
      @(negedge clk); mvalid = 1'b0;
      chk("s1_wen_now", smemwen, 1);
      @(negedge clk);
      chk("s1_rdy", sready, 1);
      chk("s1_wen_off", smemwen, 0);
      idle(3);
      chk("s1_hold", smemaddr, 12'h3A5);
      chk("s1_n", wq.size(), 1);
      while (wq.size() < 1) wq.push_back(nullev());
      chk("s1_cyc", wq[0].c, c + 1);
      chk("s1_lat", wq[0].c - s, 12);
      chk("s1_addr", wq[0].a, 12'h3A5);
      chk("s1_data", wq[0].d, 8'hC3);

      // Same write with input gaps
      wq.delete();
      send_hdr(12'h3A5, 4'd0, 1'b1, 3, 3);
      s = start_c;
      send_word(8'hC3, 1, 3);
      idle(4);
      chk("s4_n", wq.size(), 1);
      while (wq.size() < 1) wq.push_back(nullev());
      chk("s4_lat", wq[0].c - s, 18);
      chk("s4_addr", wq[0].a, 12'h3A5);
      chk("s4_data", wq[0].d, 8'hC3);

      // Burst write wrapping the address; a junk beat is offered during every WMEM
      wq.delete();
      send_hdr(12'hFFE, 4'd3, 1'b1, -1, 0);
      for (int w = 0; w < 4; w++) begin
         send_word(words[w], -1, 0);
         beat(2'b11, 1'b1);
      end
      idle(3);
      chk("s2_n", wq.size(), 4);
      while (wq.size() < 4) wq.push_back(nullev());
      for (int w = 0; w < 4; w++) begin
         chk($sformatf("s2_addr%0d", w), wq[w].a, baddr[w]);
         chk($sformatf("s2_data%0d", w), wq[w].d, words[w]);
      end
      chk("s2_span", wq[3].c - wq[0].c, 15);
      chk("s2_rdy", sready, 1);

      // Reset during word 3 of a burst
      wq.delete();
      send_hdr(12'hFFE, 4'd3, 1'b1, -1, 0);
      for (int w = 0; w < 2; w++) begin
         send_word(words[w], -1, 0);
         beat(2'b11, 1'b1);
      end
      beat(2'b11, 1'b1);
      beat(2'b00, 1'b1);
      @(negedge clk); rst = 1'b1; mvalid = 1'b0;
      @(negedge clk); rst = 1'b0;
      chk("s5_rdy", sready, 1);
      chk("s5_wen", smemwen, 0);
      chk("s5_ren", smemren, 0);
      chk("s5_svalid", svalid, 0);
      idle(4);
      chk("s5_n", wq.size(), 2);
      wq.delete();
      send_hdr(12'h123, 4'd0, 1'b1, -1, 0);
      send_word(8'h5E, -1, 0);
      idle(3);
      chk("s5_post_n", wq.size(), 1);
      while (wq.size() < 1) wq.push_back(nullev());
      chk("s5_post_addr", wq[0].a, 12'h123);
      chk("s5_post_data", wq[0].d, 8'h5E);

      // Single read
      wq.delete(); rq.delete(); vq.delete();
      mem[12'h010] = 8'h5A;
      send_hdr(12'h010, 4'd0, 1'b0, -1, 0);
      c = last_c;
      idle(12);
      chk("s3_ren_n", rq.size(), 1);
      chk("s3_sv_n", vq.size(), 4);
      while (rq.size() < 1) rq.push_back(nullev());
      while (vq.size() < 4) vq.push_back(nullev());
      chk("s3_ren_cyc", rq[0].c, c + 1);
      chk("s3_addr", rq[0].a, 12'h010);
      chk("s3_first", vq[0].c - rq[0].c, 3);
      chk("s3_last", vq[3].c - rq[0].c, 6);
      chk("s3_b0", vq[0].d, 2'b10);
      chk("s3_b1", vq[1].d, 2'b10);
      chk("s3_b2", vq[2].d, 2'b01);
      chk("s3_b3", vq[3].d, 2'b01);
      chk("s3_nowr", wq.size(), 0);

      // Burst read with master noise during the read
      rq.delete(); vq.delete();
      mem[12'h7F0] = 8'hA5;
      mem[12'h7F1] = 8'h3C;
      send_hdr(12'h7F0, 4'd1, 1'b0, -1, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         mvalid = (i % 2) == 1; swdata = 2'b11; smode = 1'b1;
      end
      idle(8);
      chk("s6_ren_n", rq.size(), 2);
      chk("s6_sv_n", vq.size(), 8);
      while (rq.size() < 2) rq.push_back(nullev());
      while (vq.size() < 8) vq.push_back(nullev());
      chk("s6_addr0", rq[0].a, 12'h7F0);
      chk("s6_addr1", rq[1].a, 12'h7F1);
      chk("s6_ren_gap", rq[1].c - rq[0].c, 7);
      chk("s6_sv_gap", vq[4].c - vq[3].c, 4);
      chk("s6_w0", {vq[3].d[1:0], vq[2].d[1:0], vq[1].d[1:0], vq[0].d[1:0]}, 8'hA5);
      chk("s6_w1", {vq[7].d[1:0], vq[6].d[1:0], vq[5].d[1:0], vq[4].d[1:0]}, 8'h3C);
      chk("s6_nowr", wq.size(), 0);
      chk("s6_rdy", sready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
